inference_scheduler: RTL and testbench
======================================

Name: inference_scheduler

Overview:
- Shares one NETWORK inference pipeline between NUM_REQ independent requesters.
- Uses round-robin arbitration and allows one inference in flight at a time.
- Dispatches the granted input vector as a single NET_VALID_IN pulse, then waits for NET_VALID_OUT with a watchdog timeout.
- Returns the result, tagged with the requester ID, through a valid/ready response port.
- Holds off new grants while the SCI weight-configuration engine signals CFG_BUSY.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_WIDTH, 2, requester-ID width; 2**ID_WIDTH >= NUM_REQ.
- NUM_INPUTS, 9, input values per inference.
- OL_NEURONS, 3, output values per inference.
- FP_WIDTH, 8, fixed-point word width.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before abort; must be >= 1.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  one-hot grant/accept.
- REQ_VALUES  in  NUM_REQ*NUM_INPUTS*FP_WIDTH  requester i vector at slice [i*NUM_INPUTS*FP_WIDTH +: NUM_INPUTS*FP_WIDTH].
- CFG_BUSY  in  1  SCI configuration in progress; blocks new grants.
- NET_VALUES_IN  out  NUM_INPUTS*FP_WIDTH  vector to network.
- NET_VALID_IN  out  1  single-cycle dispatch pulse.
- NET_VALUES_OUT  in  OL_NEURONS*FP_WIDTH  network result.
- NET_VALID_OUT  in  1  network result valid.
- NET_OVERFLOW  in  1  network overflow flag.
- RESP_VALID  out  1  response valid.
- RESP_READY  in  1  response accept.
- RESP_ID  out  ID_WIDTH  requester index of the response.
- RESP_VALUES  out  OL_NEURONS*FP_WIDTH  result; all zero on timeout.
- RESP_OVERFLOW  out  1  NET_OVERFLOW was seen during this inference.
- RESP_TIMEOUT  out  1  inference aborted by watchdog.
- BUSY  out  1  state != IDLE.
- STRAY  out  1  sticky: NET_VALID_OUT seen outside WAIT.

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE; rr_ptr=0; counter=0; STRAY=0.
  - All registered outputs go to 0.
  - REQ_READY=0 while RST is high.
- FSM states: IDLE, DISPATCH, WAIT, RESPOND.
- IDLE:
  - Grant is combinational: the first i with REQ_VALID[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - REQ_READY[g]=1 only when CFG_BUSY=0; otherwise REQ_READY=0.
  - On handshake, latch REQ_VALUES slice g and ID g; next state DISPATCH.
  - With no valid request or CFG_BUSY=1, stay in IDLE.
  - REQ_READY is 0 in all states other than IDLE.
- DISPATCH (one cycle):
  - NET_VALID_IN=1 and NET_VALUES_IN=latched vector.
  - Clear counter and overflow accumulator; next state WAIT.
  - NET_VALUES_IN holds the latched vector until the next grant.
- WAIT:
  - Counter increments each cycle.
  - Overflow accumulator |= NET_OVERFLOW, including the NET_VALID_OUT cycle.
  - On NET_VALID_OUT=1: capture NET_VALUES_OUT, set RESP_TIMEOUT=0, go to RESPOND.
  - Else if counter == TIMEOUT_CYCLES-1: set RESP_VALUES=0 and RESP_TIMEOUT=1, go to RESPOND.
  - If NET_VALID_OUT arrives in the same cycle as timeout expiry, the valid wins.
- Timing, with D = the DISPATCH cycle:
  - The WAIT window is D+1 .. D+TIMEOUT_CYCLES.
  - A result in that window at cycle V gives RESP_VALID at V+1.
  - A timeout gives RESP_VALID at D+TIMEOUT_CYCLES+1.
  - Minimum request-to-response latency is 3 cycles: grant N, dispatch N+1, result N+2, RESP_VALID N+3.
- RESPOND:
  - RESP_VALID=1; RESP_ID, RESP_VALUES, RESP_OVERFLOW and RESP_TIMEOUT are stable until RESP_READY=1.
  - On handshake: rr_ptr = (g+1) mod NUM_REQ; next state IDLE; RESP_VALID drops the next cycle.
- Grants are never issued back to back: at least one IDLE cycle separates responses.
- Stray results: NET_VALID_OUT in IDLE, DISPATCH or RESPOND is ignored for data and sets STRAY. STRAY clears only on reset. A late result after a timeout is therefore flagged, never delivered.
- CFG_BUSY asserting in DISPATCH, WAIT or RESPOND does not abort the inference; it only gates the next grant.
- A requester dropping REQ_VALID while not granted is legal; that requester is simply not selected.
- Reset during WAIT or RESPOND: the in-flight inference is discarded; no response is produced after reset.

Test Plan:
- Single request, no contention: REQ_VALID[2]=1, vector 0x01..0x09, NET_VALID_OUT 5 cycles after NET_VALID_IN with {0x20,0xE0,0x20} → one NET_VALID_IN pulse carrying the vector; RESP_VALID one cycle after the result with RESP_ID=2, RESP_VALUES={0x20,0xE0,0x20}, OVERFLOW=0, TIMEOUT=0.
- Round-robin fairness: all four REQ_VALID held high and RESP_READY=1 → grant order 0,1,2,3,0; REQ_READY strictly one-hot; no grant while BUSY=1.
- Configuration gating: CFG_BUSY=1 with REQ_VALID[1]=1 for 20 cycles → REQ_READY=0 and no NET_VALID_IN; CFG_BUSY falls → grant to 1 in the same cycle.
- Timeout and stray: TIMEOUT_CYCLES=8, network silent → RESP_VALID at D+9 with TIMEOUT=1 and RESP_VALUES=0. A result arriving at D+12 sets STRAY=1 and produces no second response. A result at exactly D+8 is a success.
- Overflow and backpressure: NET_OVERFLOW pulsed 2 cycles before the result; RESP_READY held low for 4 cycles → RESP_OVERFLOW=1; all response fields stable across the 4 stalled cycles; IDLE is re-entered only after the handshake.
- Reset mid-WAIT: RST pulsed 3 cycles after dispatch → all outputs 0 asynchronously; a later NET_VALID_OUT sets STRAY and yields no RESP_VALID; the next grant goes to requester 0.

Source files
------------

// File: rtl/inference_scheduler.sv
// Round-robin scheduler sharing one inference pipeline between NUM_REQ requesters.
// One inference in flight at a time, guarded by a watchdog, with a valid/ready response port.
module inference_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned NUM_INPUTS     = 9,
    parameter int unsigned OL_NEURONS     = 3,
    parameter int unsigned FP_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [NUM_REQ-1:0]                     REQ_VALID,
    output logic [NUM_REQ-1:0]                     REQ_READY,
    input  logic [NUM_REQ*NUM_INPUTS*FP_WIDTH-1:0] REQ_VALUES,
    input  logic                                   CFG_BUSY,
    output logic [NUM_INPUTS*FP_WIDTH-1:0]         NET_VALUES_IN,
    output logic                                   NET_VALID_IN,
    input  logic [OL_NEURONS*FP_WIDTH-1:0]         NET_VALUES_OUT,
    input  logic                                   NET_VALID_OUT,
    input  logic                                   NET_OVERFLOW,
    output logic                                   RESP_VALID,
    input  logic                                   RESP_READY,
    output logic [ID_WIDTH-1:0]                    RESP_ID,
    output logic [OL_NEURONS*FP_WIDTH-1:0]         RESP_VALUES,
    output logic                                   RESP_OVERFLOW,
    output logic                                   RESP_TIMEOUT,
    output logic                                   BUSY,
    output logic                                   STRAY
);

    localparam int unsigned VEC_W = NUM_INPUTS * FP_WIDTH;
    localparam int unsigned RES_W = OL_NEURONS * FP_WIDTH;
    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StDispatch, StWait, StRespond} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                tmo_q, tmo_d;
    logic                stray_q, stray_d;

    logic                gnt_found;
    logic [ID_WIDTH-1:0] gnt_id;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_found && REQ_VALID[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        vec_d     = vec_q;
        id_d      = id_q;
        res_d     = res_q;
        tmo_d     = tmo_q;
        stray_d   = stray_q | (NET_VALID_OUT && (state_q != StWait));
        REQ_READY = '0;

        unique case (state_q)
            StIdle: begin
                if (!RST && gnt_found && !CFG_BUSY) begin
                    REQ_READY = NUM_REQ'(1) << gnt_id;
                    vec_d     = REQ_VALUES[int'(gnt_id)*VEC_W +: VEC_W];
                    id_d      = gnt_id;
                    state_d   = StDispatch;
                end
            end
            StDispatch: begin
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = ovf_q | NET_OVERFLOW;
                // A result arriving on the expiry cycle still counts as a success.
                if (NET_VALID_OUT) begin
                    res_d   = NET_VALUES_OUT;
                    tmo_d   = 1'b0;
                    state_d = StRespond;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                if (RESP_READY) begin
                    rr_ptr_d = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            vec_q    <= '0;
            id_q     <= '0;
            res_q    <= '0;
            tmo_q    <= 1'b0;
            stray_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            vec_q    <= vec_d;
            id_q     <= id_d;
            res_q    <= res_d;
            tmo_q    <= tmo_d;
            stray_q  <= stray_d;
        end
    end

    assign NET_VALUES_IN = vec_q;
    assign NET_VALID_IN  = (state_q == StDispatch);
    assign RESP_VALID    = (state_q == StRespond);
    assign RESP_ID       = id_q;
    assign RESP_VALUES   = res_q;
    assign RESP_OVERFLOW = ovf_q;
    assign RESP_TIMEOUT  = tmo_q;
    assign BUSY          = (state_q != StIdle);
    assign STRAY         = stray_q;

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench for inference_scheduler: expected responses are queued when results are
// driven and compared when the response handshake completes.
module tb_inference_scheduler;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int NI  = 9;
    localparam int OL  = 3;
    localparam int FW  = 8;
    localparam int TMO = 8;
    localparam int VW  = NI * FW;
    localparam int RW  = OL * FW;

    logic               CLK, RST;
    logic [NR-1:0]      REQ_VALID, REQ_READY;
    logic [NR*VW-1:0]   REQ_VALUES;
    logic               CFG_BUSY;
    logic [VW-1:0]      NET_VALUES_IN;
    logic               NET_VALID_IN;
    logic [RW-1:0]      NET_VALUES_OUT;
    logic               NET_VALID_OUT, NET_OVERFLOW;
    logic               RESP_VALID, RESP_READY;
    logic [IW-1:0]      RESP_ID;
    logic [RW-1:0]      RESP_VALUES;
    logic               RESP_OVERFLOW, RESP_TIMEOUT, BUSY, STRAY;

    inference_scheduler #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .NUM_INPUTS(NI), .OL_NEURONS(OL), .FP_WIDTH(FW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_VALUES(REQ_VALUES), .CFG_BUSY(CFG_BUSY), .NET_VALUES_IN(NET_VALUES_IN),
        .NET_VALID_IN(NET_VALID_IN), .NET_VALUES_OUT(NET_VALUES_OUT),
        .NET_VALID_OUT(NET_VALID_OUT), .NET_OVERFLOW(NET_OVERFLOW), .RESP_VALID(RESP_VALID),
        .RESP_READY(RESP_READY), .RESP_ID(RESP_ID), .RESP_VALUES(RESP_VALUES),
        .RESP_OVERFLOW(RESP_OVERFLOW), .RESP_TIMEOUT(RESP_TIMEOUT), .BUSY(BUSY), .STRAY(STRAY)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [RW-1:0] vals;
        logic          ovf;
        logic          tmo;
        int            exp_cyc;
    } resp_t;

    resp_t         sb[$];
    logic [VW-1:0] vexp[$];
    int            grant_log[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            disp_cnt = 0;
    int            bases[NR] = '{8'h41, 8'h11, 8'h01, 8'h31};
    logic          auto_net = 1'b0;
    logic [RW-1:0] auto_vals = 24'h123456;

    logic          prev_valid = 1'b0;
    int            rise_cyc = 0;
    logic [IW-1:0] held_id;
    logic [RW-1:0] held_vals;
    logic          held_ovf, held_tmo;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_vec(input int base);
        logic [VW-1:0] v;
        for (int j = 0; j < NI; j++) v[j*FW +: FW] = FW'(base + j);
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_req(input logic [NR-1:0] m, output int gc);
        REQ_VALID = m;
        gc = cyc;
        tick();
        REQ_VALID = '0;
    endtask

    task automatic wait_dispatch(output int d);
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (NET_VALID_IN) begin
                d = cyc;
                return;
            end
        end
        check("dispatch_seen", 0, 1);
        d = cyc;
    endtask

    // Entered at the negedge of the dispatch cycle D; the result is driven in cycle D+dly.
    task automatic net_reply(input int dly, input logic [RW-1:0] vals, input int ovf_at,
                             input bit deliver, input logic [IW-1:0] id, input logic exp_ovf);
        resp_t r;
        for (int k = 1; k <= dly; k++) begin
            tick();
            NET_OVERFLOW  = (k == ovf_at);
            NET_VALID_OUT = (k == dly);
            if (k == dly) begin
                NET_VALUES_OUT = vals;
                if (deliver) begin
                    r.id = id; r.vals = vals; r.ovf = exp_ovf; r.tmo = 1'b0; r.exp_cyc = cyc + 1;
                    sb.push_back(r);
                end
            end
        end
        tick();
        NET_VALID_OUT = 1'b0;
        NET_OVERFLOW  = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (!BUSY && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
    endtask

    // Background network used for the round-robin run: answers one cycle after dispatch.
    always begin
        @(negedge CLK);
        if (auto_net && NET_VALID_IN && !RST) begin
            tick();
            NET_VALUES_OUT = auto_vals;
            NET_VALID_OUT  = 1'b1;
            tick();
            NET_VALID_OUT  = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 1'b0;
        end else begin
            if (RESP_VALID && !prev_valid) begin
                rise_cyc  = cyc;
                held_id   = RESP_ID;
                held_vals = RESP_VALUES;
                held_ovf  = RESP_OVERFLOW;
                held_tmo  = RESP_TIMEOUT;
            end else if (RESP_VALID) begin
                check("stall_id", RESP_ID, held_id);
                check("stall_vals", RESP_VALUES, held_vals);
                check("stall_ovf", RESP_OVERFLOW, held_ovf);
                check("stall_tmo", RESP_TIMEOUT, held_tmo);
            end
            if (RESP_VALID && RESP_READY) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    resp_t r;
                    r = sb.pop_front();
                    check("resp_id", RESP_ID, r.id);
                    check("resp_vals", RESP_VALUES, r.vals);
                    check("resp_ovf", RESP_OVERFLOW, r.ovf);
                    check("resp_tmo", RESP_TIMEOUT, r.tmo);
                    check("resp_cycle", rise_cyc, r.exp_cyc);
                end
            end
            prev_valid = RESP_VALID && !RESP_READY;
            if (NET_VALID_IN) begin
                disp_cnt++;
                if (vexp.size() == 0) check("unexpected_dispatch", 1, 0);
                else check("dispatch_vec", NET_VALUES_IN, vexp.pop_front());
            end
            if (|REQ_READY) begin
                check("ready_onehot", $onehot(REQ_READY), 1);
                check("ready_not_busy", BUSY, 0);
                for (int i = 0; i < NR; i++) if (REQ_READY[i] && REQ_VALID[i]) grant_log.push_back(i);
            end
        end
    end

    initial begin
        int gc, d, dc0, g;
        int order[5] = '{0, 1, 2, 3, 0};
        resp_t r;

        RST = 1'b1; CFG_BUSY = 1'b0; NET_VALUES_OUT = '0; NET_VALID_OUT = 1'b0;
        NET_OVERFLOW = 1'b0; RESP_READY = 1'b1;
        for (int i = 0; i < NR; i++) REQ_VALUES[i*VW +: VW] = mk_vec(bases[i]);
        REQ_VALID = '1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", REQ_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_resp_valid", RESP_VALID, 0);
        check("rst_net_valid", NET_VALID_IN, 0);
        check("rst_stray", STRAY, 0);
        check("rst_net_vals", NET_VALUES_IN, 0);
        REQ_VALID = '0;
        RST = 1'b0;
        tick();

        // Round-robin with all requesters pending.
        grant_log.delete();
        auto_net = 1'b1;
        REQ_VALID = '1;
        for (int k = 0; k < 5; k++) begin
            vexp.push_back(mk_vec(bases[order[k]]));
            wait_dispatch(d);
            r.id = IW'(order[k]); r.vals = auto_vals; r.ovf = 1'b0; r.tmo = 1'b0;
            r.exp_cyc = d + 2;
            sb.push_back(r);
        end
        REQ_VALID = '0;
        wait_idle();
        auto_net = 1'b0;
        check("rr_count", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            g = (k < grant_log.size()) ? grant_log[k] : -1;
            check("rr_order", g, order[k]);
        end

        // Single request, no contention.
        dc0 = disp_cnt;
        vexp.push_back(mk_vec(8'h01));
        do_req(4'b0100, gc);
        wait_dispatch(d);
        check("single_latency", d, gc + 1);
        net_reply(5, 24'h20E020, 0, 1'b1, 2'd2, 1'b0);
        wait_idle();
        check("single_pulses", disp_cnt - dc0, 1);

        // Configuration gating.
        dc0 = disp_cnt;
        CFG_BUSY = 1'b1;
        REQ_VALID = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            check("cfg_ready_low", REQ_READY, 0);
        end
        check("cfg_no_dispatch", disp_cnt - dc0, 0);
        vexp.push_back(mk_vec(bases[1]));
        tick();
        CFG_BUSY = 1'b0;
        #1;
        check("cfg_release_grant", REQ_READY, 4'b0010);
        gc = cyc;
        tick();
        REQ_VALID = '0;
        wait_dispatch(d);
        check("cfg_latency", d, gc + 1);
        net_reply(1, 24'hA5A5A5, 0, 1'b1, 2'd1, 1'b0);
        wait_idle();

        // Timeout, then a late result that must only raise STRAY.
        vexp.push_back(mk_vec(bases[3]));
        do_req(4'b1000, gc);
        wait_dispatch(d);
        r.id = 2'd3; r.vals = '0; r.ovf = 1'b0; r.tmo = 1'b1; r.exp_cyc = d + TMO + 1;
        sb.push_back(r);
        check("stray_before", STRAY, 0);
        net_reply(12, 24'hDEAD00, 0, 1'b0, 2'd3, 1'b0);
        check("stray_after_late", STRAY, 1);
        repeat (3) tick();
        check("tmo_sb_drained", sb.size(), 0);
        check("tmo_no_second_resp", RESP_VALID, 0);

        // Result on the last WAIT cycle is a success.
        vexp.push_back(mk_vec(bases[0]));
        do_req(4'b0001, gc);
        wait_dispatch(d);
        net_reply(TMO, 24'h0F0F0F, 0, 1'b1, 2'd0, 1'b0);
        wait_idle();

        // Overflow and backpressure.
        RESP_READY = 1'b0;
        vexp.push_back(mk_vec(bases[1]));
        do_req(4'b0010, gc);
        wait_dispatch(d);
        net_reply(5, 24'h7F807F, 3, 1'b1, 2'd1, 1'b1);
        check("bp_valid_first", RESP_VALID, 1);
        repeat (3) tick();
        check("bp_valid_held", RESP_VALID, 1);
        tick();
        RESP_READY = 1'b1;
        check("bp_busy_before_hs", BUSY, 1);
        tick();
        check("bp_idle_after_hs", BUSY, 0);
        check("bp_valid_dropped", RESP_VALID, 0);
        check("bp_sb_drained", sb.size(), 0);

        // Reset in the middle of WAIT.
        vexp.push_back(mk_vec(bases[2]));
        do_req(4'b0100, gc);
        wait_dispatch(d);
        repeat (3) tick();
        #2;
        RST = 1'b1;
        #1;
        check("mrst_busy", BUSY, 0);
        check("mrst_resp_valid", RESP_VALID, 0);
        check("mrst_net_valid", NET_VALID_IN, 0);
        check("mrst_stray", STRAY, 0);
        check("mrst_net_vals", NET_VALUES_IN, 0);
        check("mrst_resp_vals", RESP_VALUES, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) tick();
        NET_VALUES_OUT = 24'h555555;
        NET_VALID_OUT = 1'b1;
        tick();
        NET_VALID_OUT = 1'b0;
        check("mrst_stray_set", STRAY, 1);
        repeat (3) tick();
        check("mrst_no_resp", RESP_VALID, 0);
        grant_log.delete();
        vexp.push_back(mk_vec(bases[0]));
        do_req(4'b1001, gc);
        wait_dispatch(d);
        g = (grant_log.size() > 0) ? grant_log[0] : -1;
        check("mrst_next_grant", g, 0);
        net_reply(2, 24'h010203, 0, 1'b1, 2'd0, 1'b0);
        wait_idle();

        check("final_sb_empty", sb.size(), 0);
        check("final_vexp_empty", vexp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
